traffic_conflict_monitor: RTL and testbench

Downstream safety stage between the `Traffic` light controller and the lamp drivers. It registers the controller's `NS`/`EW` lamp codes and checks each cycle for conflicting greens, illegal encodings, illegal phase sequences and short yellows. Clean codes pass through to the lamps. On the first violation it latches a fault code and forces both approaches to flashing red until reset.

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/traffic_flasher.sv | 26 ++
 rtl/traffic_conflict_monitor.sv | 88 ++++++++
 tb/tb_traffic_conflict_monitor.sv | 138 +++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp codes, fault codes, monitor states and transition helpers
package traffic_pkg;
  localparam logic [3:0] LAMP_RED = 4'b0001;
  localparam logic [3:0] LAMP_YEL = 4'b0010;
  localparam logic [3:0] LAMP_GRN = 4'b0100;
  localparam logic [3:0] LAMP_OFF = 4'b0000;
  typedef enum logic [2:0] {
    FLT_NONE      = 3'd0,
    FLT_CONFLICT  = 3'd1,
    FLT_ENCODING  = 3'd2,
    FLT_SEQUENCE  = 3'd3,
    FLT_SHORT_YEL = 3'd4,
    FLT_WATCHDOG  = 3'd5
  } fault_e;
  typedef enum logic {NORMAL = 1'b0, FAULT = 1'b1} state_e;
  function automatic logic lamp_legal(input logic [3:0] c);
    return c == LAMP_RED || c == LAMP_YEL || c == LAMP_GRN;
  endfunction
  function automatic logic step_ok(input logic [3:0] p, input logic [3:0] q);
    return p == q || (p == LAMP_RED && q == LAMP_GRN) || (p == LAMP_GRN && q == LAMP_YEL) ||
           (p == LAMP_YEL && q == LAMP_RED);
  endfunction
endpackage

// File: rtl/traffic_flasher.sv
// traffic_flasher: half-period phase counter, on=1 for FLASH_HALF cycles then 0, restarts red-on when enabled
module traffic_flasher #(
  parameter int FLASH_HALF = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic on
);
  localparam int W = $clog2(FLASH_HALF) + 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      on  <= 1'b1;
    end else if (!enable) begin
      cnt <= '0;
      on  <= 1'b1;
    end else if (cnt == W'(FLASH_HALF - 1)) begin
      cnt <= '0;
      on  <= ~on;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: registers controller lamp codes, latches the first safety violation and flashes red.
// Optional stuck-controller watchdog (fault code 5) enabled by defining TRAFFIC_WATCHDOG_EN.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 1500,
  parameter int FLASH_HALF = 5000,
  parameter int MAX_DWELL  = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ns_in,
  input  logic [3:0] ew_in,
  output logic [3:0] ns_lamp,
  output logic [3:0] ew_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  logic [3:0] ns_q, ew_q, ns_p, ew_p, ns_r, ew_r;
  logic [YW-1:0] ns_yc, ew_yc;
  state_e state, state_n;
  fault_e code_r, code_n;
  logic on, conflict, encoding, seq_bad, short_yel, watchdog;
  assign conflict  = ns_q != LAMP_RED && ew_q != LAMP_RED;
  assign encoding  = !lamp_legal(ns_q) || !lamp_legal(ew_q);
  assign seq_bad   = !step_ok(ns_p, ns_q) || !step_ok(ew_p, ew_q);
  assign short_yel = (ns_p == LAMP_YEL && ns_q == LAMP_RED && ns_yc < YW'(MIN_YELLOW)) ||
                     (ew_p == LAMP_YEL && ew_q == LAMP_RED && ew_yc < YW'(MIN_YELLOW));
`ifdef TRAFFIC_WATCHDOG_EN
  localparam int DW = $clog2(MAX_DWELL + 1);
  logic [DW-1:0] dwell;
  logic changed;
  assign changed  = {ns_q, ew_q} != {ns_p, ew_p};
  assign watchdog = !changed && dwell >= DW'(MAX_DWELL - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dwell <= '0;
    else dwell <= changed ? '0 : (dwell == DW'(MAX_DWELL) ? dwell : dwell + 1'b1);
  end
`else
  // without the watchdog MAX_DWELL has no effect; this keeps it referenced
  assign watchdog = MAX_DWELL < 0;
`endif
  always_comb begin
    state_n = state;
    code_n  = code_r;
    if (state == NORMAL && (conflict || encoding || seq_bad || short_yel || watchdog)) begin
      state_n = FAULT;
      code_n  = conflict ? FLT_CONFLICT : encoding ? FLT_ENCODING : seq_bad ? FLT_SEQUENCE :
                short_yel ? FLT_SHORT_YEL : FLT_WATCHDOG;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_q   <= LAMP_RED;
      ew_q   <= LAMP_RED;
      ns_p   <= LAMP_RED;
      ew_p   <= LAMP_RED;
      ns_r   <= LAMP_RED;
      ew_r   <= LAMP_RED;
      ns_yc  <= '0;
      ew_yc  <= '0;
      state  <= NORMAL;
      code_r <= FLT_NONE;
    end else begin
      ns_q   <= ns_in;
      ew_q   <= ew_in;
      ns_p   <= ns_q;
      ew_p   <= ew_q;
      ns_yc  <= ns_q == LAMP_YEL ? (ns_yc == YW'(MIN_YELLOW) ? ns_yc : ns_yc + 1'b1) : '0;
      ew_yc  <= ew_q == LAMP_YEL ? (ew_yc == YW'(MIN_YELLOW) ? ew_yc : ew_yc + 1'b1) : '0;
      ns_r   <= state_n == NORMAL ? ns_q : LAMP_RED;
      ew_r   <= state_n == NORMAL ? ew_q : LAMP_RED;
      state  <= state_n;
      code_r <= code_n;
    end
  end
  traffic_flasher #(.FLASH_HALF(FLASH_HALF)) u_flasher (
    .clk   (clk),
    .rst   (rst),
    .enable(state == FAULT),
    .on    (on)
  );
  assign fault      = state == FAULT;
  assign fault_code = code_r;
  assign ns_lamp    = fault ? (on ? LAMP_RED : LAMP_OFF) : ns_r;
  assign ew_lamp    = fault ? (on ? LAMP_RED : LAMP_OFF) : ew_r;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: table-driven scoreboard bench plus a hand-written flash/reset sequence
module tb_traffic_conflict_monitor;
  localparam logic [3:0] R = 4'b0001, Y = 4'b0010, G = 4'b0100, O = 4'b0000;
  typedef struct {
    bit rst;
    int n;
    logic [3:0] ns, ew, ens, eew;
    logic ef;
    logic [2:0] ec;
    string nm;
  } vec_t;
  typedef struct {
    logic [3:0] ens, eew;
    logic ef;
    logic [2:0] ec;
    string nm;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [3:0] ns_in = R, ew_in = R, ns_lamp, ew_lamp;
  logic fault;
  logic [2:0] fault_code;
  int total = 0, bad = 0;
  vec_t tbl[$];
  exp_t sb[$];
  traffic_conflict_monitor #(.FLASH_HALF(4)) dut (
    .clk(clk), .rst(rst), .ns_in(ns_in), .ew_in(ew_in),
    .ns_lamp(ns_lamp), .ew_lamp(ew_lamp), .fault(fault), .fault_code(fault_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [3:0] ens, input logic [3:0] eew,
                     input logic ef, input logic [2:0] ec);
    total++;
    if (ns_lamp !== ens || ew_lamp !== eew || fault !== ef || fault_code !== ec) begin
      bad++;
      $display("FAIL %s: got ns=%b ew=%b fault=%b code=%0d, want ns=%b ew=%b fault=%b code=%0d",
               nm, ns_lamp, ew_lamp, fault, fault_code, ens, eew, ef, ec);
    end
  endtask
  task automatic pop_chk();
    exp_t e;
    e = sb.pop_front();
    chk(e.nm, e.ens, e.eew, e.ef, e.ec);
  endtask
  task automatic cyc(input vec_t v);
    exp_t e;
    @(negedge clk);
    if (sb.size() >= 2) pop_chk();
    ns_in = v.ns;
    ew_in = v.ew;
    e.ens = v.ens; e.eew = v.eew; e.ef = v.ef; e.ec = v.ec; e.nm = v.nm;
    sb.push_back(e);
  endtask
  task automatic flush();
    repeat (2) begin
      @(negedge clk);
      if (sb.size() > 0) pop_chk();
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    ns_in = R;
    ew_in = R;
    #1 chk("reset", R, R, 1'b0, 3'd0);
    @(negedge clk);
    rst = 0;
    sb.delete();
  endtask
  task automatic add(input bit r, input int n, input logic [3:0] ns, input logic [3:0] ew,
                     input logic [3:0] ens, input logic [3:0] eew, input logic ef,
                     input logic [2:0] ec, input string nm);
    vec_t v;
    v.rst = r; v.n = n; v.ns = ns; v.ew = ew; v.ens = ens; v.eew = eew; v.ef = ef; v.ec = ec; v.nm = nm;
    tbl.push_back(v);
  endtask
  initial begin
    add(1, 3, R, R, R, R, 0, 0, "idle");
    add(0, 200, G, R, G, R, 0, 0, "ns_green");
    add(0, 1500, Y, R, Y, R, 0, 0, "ns_yellow_full");
    add(0, 200, R, G, R, G, 0, 0, "ew_green");
    add(0, 1500, R, Y, R, Y, 0, 0, "ew_yellow_full");
    add(0, 3, R, R, R, R, 0, 0, "all_red");
    add(1, 2, R, R, R, R, 0, 0, "pre_conflict");
    add(0, 1, G, G, R, R, 1, 1, "conflict");
    add(0, 3, 4'b1000, R, R, R, 1, 1, "absorbing");
    add(1, 2, R, R, R, R, 0, 0, "pre_short");
    add(0, 5, G, R, G, R, 0, 0, "short_green");
    add(0, 1499, Y, R, Y, R, 0, 0, "short_yellow_hold");
    add(0, 1, R, R, R, R, 1, 4, "short_yellow");
    add(0, 3, R, R, R, R, 1, 4, "short_yellow_after");
    add(1, 2, R, R, R, R, 0, 0, "pre_multi");
    add(0, 3, R, G, R, G, 0, 0, "multi_ew_green");
    add(0, 1, 4'b0110, G, R, R, 1, 1, "multi_violation");
    add(0, 3, R, R, R, R, 1, 1, "multi_after");
    add(1, 2, R, R, R, R, 0, 0, "pre_red_yel");
    add(0, 1, Y, R, R, R, 1, 3, "red_to_yellow");
    add(0, 3, R, R, R, R, 1, 3, "red_to_yellow_after");
    add(1, 2, R, R, R, R, 0, 0, "pre_encoding");
    add(0, 1, R, 4'b1000, R, R, 1, 2, "encoding");
    add(0, 3, R, R, R, R, 1, 2, "encoding_after");
    add(1, 2, R, R, R, R, 0, 0, "pre_grn_red");
    add(0, 4, G, R, G, R, 0, 0, "grn_hold");
    add(0, 1, R, R, R, R, 1, 3, "green_to_red");
    add(0, 3, R, R, R, R, 1, 3, "green_to_red_after");
    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        flush();
        do_reset();
      end
      repeat (tbl[i].n) cyc(tbl[i]);
    end
    flush();
    do_reset();
    @(negedge clk);
    ns_in = G;
    ew_in = G;
    @(negedge clk);
    ns_in = R;
    ew_in = R;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("flash_%0d", i), ((i / 4) % 2 == 0) ? R : O, ((i / 4) % 2 == 0) ? R : O, 1'b1, 3'd1);
    end
    #2 rst = 1;
    #1 chk("reset_mid_flash", R, R, 1'b0, 3'd0);
    @(negedge clk);
    rst = 0;
    ns_in = G;
    ew_in = R;
    @(negedge clk);
    chk("post_reset_edge1", R, R, 1'b0, 3'd0);
    @(negedge clk);
    chk("post_reset_edge2", G, R, 1'b0, 3'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
